pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central pipeline control unit that produces the 6-bit stall vector and the flush signal consumed by every inter-stage register (pc_reg, if_id, id_ex, ex_mem, mem_wb).
- Merges stall requests from IF, ID, EX and MEM, and exception reports from MEM, into one consistent stall/flush decision per cycle.
- Tracks stall duration with a watchdog and keeps saturating per-source stall-cycle performance counters.

Parameters:
EXC_VECTOR, 32'h0000_0020, handler entry PC for all non-ERET exceptions
WDOG_LIMIT, 1024, consecutive stalled cycles before stall_timeout sets
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  reset
stallreq_if  in  1  IF stage requests stall (fetch miss)
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (multi-cycle op)
stallreq_mem  in  1  MEM stage requests stall (data access wait)
excepttype  in  32  exception code from MEM; 0 = none
cp0_epc  in  32  EPC value used as target on ERET
stall  out  6  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB; 1 = hold stage
flush  out  1  clear all pipeline registers this cycle
new_pc  out  32  redirect target, valid when flush=1
stall_src  out  3  registered last stall source: 0 none, 1 IF, 2 ID, 3 EX, 4 MEM
stall_timeout  out  1  sticky; set when the watchdog expires
cnt_if, cnt_id, cnt_ex, cnt_mem  out  CNT_W  saturating stalled-cycle counts per winning source

Behaviour:
- Reset: synchronous, active-high on rst; clock clk. While rst=1: stall=0, flush=0, new_pc=0. Next edge: stall_src=0, stall_timeout=0, all counters=0, watchdog=0, guard=0.
- stall, flush and new_pc are combinational in the same cycle as the requests. Pipeline registers sample them on the next edge. Zero latency.
- Flush decision, highest priority:
  - flush=1 when excepttype!=0 and guard=0.
  - While flush=1, stall=6'b000000.
  - new_pc = cp0_epc when excepttype==32'h0000_000e (ERET), otherwise EXC_VECTOR.
- Guard:
  - guard sets for exactly one cycle after a flush cycle.
  - While guard=1, excepttype is ignored; the flushed MEM stage may still show a stale code.
- Stall encoding. With no flush, the deepest requesting stage wins; requests are supersets, not ORed per bit:
  - MEM -> 6'b011111
  - EX -> 6'b001111
  - ID -> 6'b000111
  - IF -> 6'b000011
  - none -> 6'b000000
- Contract with downstream registers: stage k with stall[k]=1 and stall[k+1]=0 inserts a NOP. stall[5] is never asserted.
- stall_src: registered each edge to the winning source code. It is 0 on flush cycles and on unstalled cycles.
- Watchdog:
  - Counter increments on each cycle with stall!=0.
  - Clears on any cycle with stall==0 or flush=1.
  - When it reaches WDOG_LIMIT-1 while still stalled, stall_timeout sets on that edge and stays set until rst.
  - The counter saturates and does not wrap.
- Performance counters:
  - Only the winning source's counter increments, by 1 per stalled cycle.
  - No increment on flush cycles.
  - Each counter saturates at all-ones.
- Simultaneous events:
  - Exception plus any stall request -> flush wins; no counter increments; watchdog clears.
  - Several stall requests -> only the deepest source is counted.
- Reset mid-stall or mid-flush: all state clears at the edge. Outputs are zero for the whole reset cycle.

Decomposition:
- Shared defines file holds:
  - stall-vector constants (STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM)
  - stall-source codes
  - exception code constants, including EXC_ERET = 32'h0000_000e
- Natural sub-module: stall_perf_cnt, one saturating CNT_W counter with enable. Instantiate it four times.

Test Plan:
- rst=1 for 2 cycles, then all inputs 0 -> stall=0, flush=0, counters=0, stall_src=0, stall_timeout=0.
- stallreq_id=1 for 3 cycles -> stall=6'b000111 each cycle; cnt_id=3; stall_src=2 after the first edge; returns to 0 one edge after the request drops.
- stallreq_if=1, stallreq_ex=1, stallreq_mem=1 together for 1 cycle -> stall=6'b011111; only cnt_mem increments (1); stall_src=4.
- excepttype=32'h0000_000e, cp0_epc=32'h0000_0400, stallreq_ex=1 in the same cycle -> flush=1, new_pc=0x400, stall=0, cnt_ex unchanged.
  - Next cycle with excepttype=0x8 still present: flush=0 (guard).
- excepttype=32'h0000_0008 -> flush=1, new_pc=0x20.
- WDOG_LIMIT=8, stallreq_mem held 10 cycles -> stall_timeout rises at the 8th stalled edge and stays 1 after the request drops, until rst.

Source files
------------

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller: stall vectors,
// stall-source codes, exception codes and small decode helpers.
package pipeline_stall_ctrl_pkg;

    // Stall vectors: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    // Stall source codes reported on stall_src
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_IF   = 3'd1,
        SRC_ID   = 3'd2,
        SRC_EX   = 3'd3,
        SRC_MEM  = 3'd4
    } stall_src_e;

    // Exception codes delivered by the MEM stage
    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Deepest requesting stage wins
    function automatic stall_src_e pick_src(input logic req_if, input logic req_id,
                                            input logic req_ex, input logic req_mem);
        stall_src_e src;
        if (req_mem) begin
            src = SRC_MEM;
        end else if (req_ex) begin
            src = SRC_EX;
        end else if (req_id) begin
            src = SRC_ID;
        end else if (req_if) begin
            src = SRC_IF;
        end else begin
            src = SRC_NONE;
        end
        return src;
    endfunction

    // A stalled stage also holds every earlier stage, so vectors are supersets
    function automatic logic [5:0] src_to_stall(input stall_src_e src);
        logic [5:0] vec;
        case (src)
            SRC_IF:  vec = STALL_IF;
            SRC_ID:  vec = STALL_ID;
            SRC_EX:  vec = STALL_EX;
            SRC_MEM: vec = STALL_MEM;
            default: vec = STALL_NONE;
        endcase
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_perf_cnt.sv
// One saturating stalled-cycle counter; holds at all-ones instead of wrapping.
module stall_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: add one when enabled and not yet saturated
    always_comb begin
        cnt_d = cnt_q;
        if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: merges stage stall requests and MEM
// exceptions into one stall vector and flush per cycle, with a stall
// watchdog and per-source saturating stall-cycle counters.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          WDOG_LIMIT = 1024,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic [31:0]      excepttype,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [2:0]       stall_src,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] cnt_if,
    output logic [CNT_W-1:0] cnt_id,
    output logic [CNT_W-1:0] cnt_ex,
    output logic [CNT_W-1:0] cnt_mem
);

    localparam int              WD_W   = $clog2(WDOG_LIMIT) + 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_ONE = WD_W'(1);

    stall_src_e      win_s;
    logic            flush_s;
    logic            stalled_s;
    logic [5:0]      stall_s;
    logic [31:0]     new_pc_s;
    logic            en_if_s;
    logic            en_id_s;
    logic            en_ex_s;
    logic            en_mem_s;

    logic            guard_q,   guard_d;
    logic [2:0]      src_q,     src_d;
    logic [WD_W-1:0] wdog_q,    wdog_d;
    logic            timeout_q, timeout_d;

    // Same-cycle decision: reset forces quiet outputs, unguarded exception flushes, else stall
    always_comb begin
        win_s    = pick_src(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
        flush_s  = 1'b0;
        stall_s  = STALL_NONE;
        new_pc_s = 32'h0000_0000;
        if (rst) begin
            flush_s  = 1'b0;
            stall_s  = STALL_NONE;
            new_pc_s = 32'h0000_0000;
        end else if ((excepttype != EXC_NONE) && !guard_q) begin
            flush_s  = 1'b1;
            stall_s  = STALL_NONE;
            new_pc_s = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
        end else begin
            flush_s  = 1'b0;
            stall_s  = src_to_stall(win_s);
            new_pc_s = 32'h0000_0000;
        end
        stalled_s = (stall_s != STALL_NONE);
    end

    // Next state for guard, source, watchdog and counter enables
    always_comb begin
        guard_d   = flush_s;
        src_d     = stalled_s ? win_s : SRC_NONE;
        timeout_d = timeout_q | (stalled_s && (wdog_q == WD_MAX));
        wdog_d    = {WD_W{1'b0}};
        if (stalled_s) begin
            if (wdog_q != WD_MAX) begin
                wdog_d = wdog_q + WD_ONE;
            end else begin
                wdog_d = wdog_q;
            end
        end else begin
            wdog_d = {WD_W{1'b0}};
        end
        en_if_s  = stalled_s && (win_s == SRC_IF);
        en_id_s  = stalled_s && (win_s == SRC_ID);
        en_ex_s  = stalled_s && (win_s == SRC_EX);
        en_mem_s = stalled_s && (win_s == SRC_MEM);
    end

    // Control state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            guard_q   <= 1'b0;
            src_q     <= 3'd0;
            wdog_q    <= {WD_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            guard_q   <= guard_d;
            src_q     <= src_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    stall_perf_cnt #(.CNT_W(CNT_W)) u_cnt_if  (.clk(clk), .rst(rst), .en(en_if_s),  .cnt(cnt_if));
    stall_perf_cnt #(.CNT_W(CNT_W)) u_cnt_id  (.clk(clk), .rst(rst), .en(en_id_s),  .cnt(cnt_id));
    stall_perf_cnt #(.CNT_W(CNT_W)) u_cnt_ex  (.clk(clk), .rst(rst), .en(en_ex_s),  .cnt(cnt_ex));
    stall_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mem (.clk(clk), .rst(rst), .en(en_mem_s), .cnt(cnt_mem));

    assign stall         = stall_s;
    assign flush         = flush_s;
    assign new_pc        = new_pc_s;
    assign stall_src     = src_q;
    assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl: directed plan steps followed
// by random stimulus, all compared against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    localparam logic [31:0] EXC_VEC = 32'h0000_0020;
    localparam int          WDL     = 8;
    localparam int          CW      = 6;
    localparam int          CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0]   excepttype, cp0_epc;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic [2:0]    stall_src;
    logic          stall_timeout;
    logic [CW-1:0] cnt_if, cnt_id, cnt_ex, cnt_mem;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.EXC_VECTOR(EXC_VEC), .WDOG_LIMIT(WDL), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excepttype(excepttype), .cp0_epc(cp0_epc),
        .stall(stall), .flush(flush), .new_pc(new_pc),
        .stall_src(stall_src), .stall_timeout(stall_timeout),
        .cnt_if(cnt_if), .cnt_id(cnt_id), .cnt_ex(cnt_ex), .cnt_mem(cnt_mem)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit m_valid = 1'b0;
    bit m_guard = 1'b0;
    int m_wd    = 0;
    bit m_to    = 1'b0;
    int m_src   = 0;
    int m_cnt[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: apply inputs, check against the model, advance the model
    task automatic cycle(input bit r, input bit fi, input bit fd, input bit fe, input bit fm,
                         input logic [31:0] exc, input logic [31:0] epc);
        int          depth;
        bit          fl;
        logic [31:0] e_stall;
        logic [31:0] e_pc;
        rst = r; stallreq_if = fi; stallreq_id = fd; stallreq_ex = fe; stallreq_mem = fm;
        excepttype = exc; cp0_epc = epc;
        @(negedge clk);
        depth   = fm ? 4 : fe ? 3 : fd ? 2 : fi ? 1 : 0;
        fl      = !r && (exc != 32'd0) && !m_guard;
        e_stall = (r || fl || depth == 0) ? 32'd0 : ((32'd1 << (depth + 1)) - 32'd1);
        e_pc    = fl ? ((exc == 32'h0000_000e) ? epc : EXC_VEC) : 32'd0;
        chk("stall", {26'd0, stall}, e_stall);
        chk("flush", {31'd0, flush}, {31'd0, fl});
        if (r || fl) chk("new_pc", new_pc, e_pc);
        if (m_valid) begin
            chk("stall_src", {29'd0, stall_src}, 32'(m_src));
            chk("stall_timeout", {31'd0, stall_timeout}, {31'd0, m_to});
            chk("cnt_if",  32'(cnt_if),  32'(m_cnt[1]));
            chk("cnt_id",  32'(cnt_id),  32'(m_cnt[2]));
            chk("cnt_ex",  32'(cnt_ex),  32'(m_cnt[3]));
            chk("cnt_mem", 32'(cnt_mem), 32'(m_cnt[4]));
        end
        if (r) begin
            m_valid = 1'b1; m_guard = 1'b0; m_wd = 0; m_to = 1'b0; m_src = 0;
            for (int k = 0; k < 5; k++) m_cnt[k] = 0;
        end else begin
            m_guard = fl;
            if (fl || depth == 0) begin
                m_src = 0;
                m_wd  = 0;
            end else begin
                m_src = depth;
                if (m_wd == WDL - 1) m_to = 1'b1;
                else m_wd = m_wd + 1;
                if (m_cnt[depth] < CMAX) m_cnt[depth] = m_cnt[depth] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exc;
        bit          r;
        for (int k = 0; k < 5; k++) m_cnt[k] = 0;
        rst = 1'b1; stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
        stallreq_mem = 1'b0; excepttype = 32'd0; cp0_epc = 32'd0;

        // Reset for two cycles, then idle
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        cycle(1, 0, 0, 0, 0, 32'd0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Load-use stall for three cycles
        repeat (3) cycle(0, 0, 1, 0, 0, 32'd0, 32'd0);
        chk("plan_cnt_id", 32'(cnt_id), 32'd3);
        chk("plan_src_id", {29'd0, stall_src}, 32'd2);
        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Several requests at once: MEM wins
        cycle(0, 1, 0, 1, 1, 32'd0, 32'd0);
        chk("plan_cnt_mem", 32'(cnt_mem), 32'd1);
        chk("plan_cnt_if",  32'(cnt_if),  32'd0);
        chk("plan_src_mem", {29'd0, stall_src}, 32'd4);

        // ERET with EX stall, then stale code under guard, then a fresh exception
        cycle(0, 0, 0, 1, 0, 32'h0000_000e, 32'h0000_0400);
        chk("plan_cnt_ex", 32'(cnt_ex), 32'd0);
        cycle(0, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_0400);
        cycle(0, 0, 0, 0, 0, 32'h0000_0008, 32'h0000_0400);
        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Watchdog: MEM held 10 cycles
        repeat (10) cycle(0, 0, 0, 0, 1, 32'd0, 32'd0);
        repeat (3) cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);
        chk("plan_timeout_sticky", {31'd0, stall_timeout}, 32'd1);

        // Counter saturation
        repeat (CMAX + 6) cycle(0, 0, 0, 0, 1, 32'd0, 32'd0);
        chk("plan_cnt_mem_sat", 32'(cnt_mem), 32'(CMAX));
        cycle(1, 0, 0, 1, 1, 32'h0000_0008, 32'd0);
        cycle(0, 0, 0, 0, 0, 32'd0, 32'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 149) == 0);
            exc = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       exc = 32'h0000_000e;
                    1:       exc = 32'h0000_0008;
                    2:       exc = 32'h0000_0004;
                    default: exc = $urandom;
                endcase
            end
            cycle(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), exc, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
